// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline register with branch resolution, forwarding and load-use detection
//
// Purpose:
//   Registers the EX-stage result into the MEM stage, resolves the branch
//   condition, and produces the forwarding selects and load-use hazard flag
//   that feed back into EX.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   stall, flush             hold the registers / load a bubble
//   ex_*                     EX-stage instruction, data and control
//   ALUresult, finalReadData2, zero
//                            EX ALU result, store data, ALU zero flag
//   wb_rd, wb_RegWrite       MEM/WB destination for the second forwarding path
//   mem_*                    registered MEM-stage outputs
//   mem_pcsrc                registered redirect decision (one cycle per taken branch)
//   forwardA, forwardB       2'b10 EX/MEM, 2'b01 MEM/WB, 2'b00 register file
//   load_use_hazard          EX source depends on the load now in MEM

module ex_mem_pipe #(
    parameter int WORD_BITWIDTH    = 32,
    parameter int REG_NUM_BITWIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        ex_valid,
    input  logic [WORD_BITWIDTH-1:0]    ALUresult,
    input  logic [WORD_BITWIDTH-1:0]    finalReadData2,
    input  logic                        zero,
    input  logic [WORD_BITWIDTH-1:0]    ex_branch_target,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_rd,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_rs2,
    input  logic                        ex_RegWrite,
    input  logic                        ex_MemRead,
    input  logic                        ex_MemWrite,
    input  logic                        ex_MemtoReg,
    input  logic                        ex_Branch,
    input  logic                        ex_Jump,
    input  logic [2:0]                  ex_funct3,
    input  logic [REG_NUM_BITWIDTH-1:0] wb_rd,
    input  logic                        wb_RegWrite,
    output logic                        mem_valid,
    output logic                        mem_RegWrite,
    output logic                        mem_MemRead,
    output logic                        mem_MemWrite,
    output logic                        mem_MemtoReg,
    output logic [WORD_BITWIDTH-1:0]    mem_ALUresult,
    output logic [WORD_BITWIDTH-1:0]    mem_writeData,
    output logic [WORD_BITWIDTH-1:0]    mem_branch_target,
    output logic [REG_NUM_BITWIDTH-1:0] mem_rd,
    output logic                        mem_pcsrc,
    output logic [1:0]                  forwardA,
    output logic [1:0]                  forwardB,
    output logic                        load_use_hazard
);

    logic taken;
    logic squash;

    always_comb begin
        taken = 1'b0;
        if (ex_Jump) begin
            taken = 1'b1;
        end else if (ex_Branch) begin
            case (ex_funct3)
                3'b000:  taken = zero;
                3'b001:  taken = !zero;
                3'b100:  taken = ALUresult[0];
                3'b101:  taken = !ALUresult[0];
                default: taken = 1'b0;
            endcase
        end
    end

    // A redirect sitting in MEM kills the wrong-path instruction now in EX,
    // which also guarantees mem_pcsrc is high for only one cycle.
    assign squash = flush | (mem_valid & mem_pcsrc);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid         <= 1'b0;
            mem_RegWrite      <= 1'b0;
            mem_MemRead       <= 1'b0;
            mem_MemWrite      <= 1'b0;
            mem_MemtoReg      <= 1'b0;
            mem_pcsrc         <= 1'b0;
            mem_ALUresult     <= '0;
            mem_writeData     <= '0;
            mem_branch_target <= '0;
            mem_rd            <= '0;
        end else if (squash) begin
            // Bubble: control cleared, data registers left as they are.
            mem_valid    <= 1'b0;
            mem_RegWrite <= 1'b0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_MemtoReg <= 1'b0;
            mem_pcsrc    <= 1'b0;
        end else if (!stall) begin
            mem_valid         <= ex_valid;
            mem_RegWrite      <= ex_RegWrite & ex_valid;
            mem_MemRead       <= ex_MemRead & ex_valid;
            mem_MemWrite      <= ex_MemWrite & ex_valid;
            mem_MemtoReg      <= ex_MemtoReg & ex_valid;
            mem_pcsrc         <= taken & ex_valid;
            mem_ALUresult     <= ALUresult;
            mem_writeData     <= finalReadData2;
            mem_branch_target <= ex_branch_target;
            mem_rd            <= ex_rd;
        end
    end

    // Loads are excluded from the EX/MEM path: their data is not available
    // until MEM/WB, so the load-use stall covers that case.
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    assign mem_fwd_ok = mem_valid & mem_RegWrite & !mem_MemtoReg & (mem_rd != '0);
    assign wb_fwd_ok  = wb_RegWrite & (wb_rd != '0);

    always_comb begin
        forwardA = 2'b00;
        if (mem_fwd_ok && (mem_rd == ex_rs1)) begin
            forwardA = 2'b10;
        end else if (wb_fwd_ok && (wb_rd == ex_rs1)) begin
            forwardA = 2'b01;
        end
    end

    always_comb begin
        forwardB = 2'b00;
        if (mem_fwd_ok && (mem_rd == ex_rs2)) begin
            forwardB = 2'b10;
        end else if (wb_fwd_ok && (wb_rd == ex_rs2)) begin
            forwardB = 2'b01;
        end
    end

    assign load_use_hazard = mem_valid & mem_MemRead & (mem_rd != '0)
                           & ((mem_rd == ex_rs1) | (mem_rd == ex_rs2)) & ex_valid;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - scoreboard testbench for ex_mem_pipe

module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ALUresult;
    logic [31:0] finalReadData2;
    logic        zero;
    logic [31:0] ex_branch_target;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_RegWrite;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_MemtoReg;
    logic        ex_Branch;
    logic        ex_Jump;
    logic [2:0]  ex_funct3;
    logic [4:0]  wb_rd;
    logic        wb_RegWrite;
    logic        mem_valid;
    logic        mem_RegWrite;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic        mem_MemtoReg;
    logic [31:0] mem_ALUresult;
    logic [31:0] mem_writeData;
    logic [31:0] mem_branch_target;
    logic [4:0]  mem_rd;
    logic        mem_pcsrc;
    logic [1:0]  forwardA;
    logic [1:0]  forwardB;
    logic        load_use_hazard;

    ex_mem_pipe #(
        .WORD_BITWIDTH    (32),
        .REG_NUM_BITWIDTH (5)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .ex_valid          (ex_valid),
        .ALUresult         (ALUresult),
        .finalReadData2    (finalReadData2),
        .zero              (zero),
        .ex_branch_target  (ex_branch_target),
        .ex_rd             (ex_rd),
        .ex_rs1            (ex_rs1),
        .ex_rs2            (ex_rs2),
        .ex_RegWrite       (ex_RegWrite),
        .ex_MemRead        (ex_MemRead),
        .ex_MemWrite       (ex_MemWrite),
        .ex_MemtoReg       (ex_MemtoReg),
        .ex_Branch         (ex_Branch),
        .ex_Jump           (ex_Jump),
        .ex_funct3         (ex_funct3),
        .wb_rd             (wb_rd),
        .wb_RegWrite       (wb_RegWrite),
        .mem_valid         (mem_valid),
        .mem_RegWrite      (mem_RegWrite),
        .mem_MemRead       (mem_MemRead),
        .mem_MemWrite      (mem_MemWrite),
        .mem_MemtoReg      (mem_MemtoReg),
        .mem_ALUresult     (mem_ALUresult),
        .mem_writeData     (mem_writeData),
        .mem_branch_target (mem_branch_target),
        .mem_rd            (mem_rd),
        .mem_pcsrc         (mem_pcsrc),
        .forwardA          (forwardA),
        .forwardB          (forwardB),
        .load_use_hazard   (load_use_hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        pcsrc;
        logic        known;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] bt;
        logic [4:0]  rd;
    } exp_t;

    exp_t model;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic branch_taken();
        if (ex_Jump) return 1'b1;
        if (!ex_Branch) return 1'b0;
        case (ex_funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return ALUresult[0];
            3'b101:  return !ALUresult[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (model.valid && model.rw && !model.m2r && model.rd != 5'd0 && model.rd == rs)
            return 2'b10;
        if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    task automatic clr_ex();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0;
        ALUresult = '0; finalReadData2 = '0; zero = 1'b0; ex_branch_target = '0;
        ex_rd = '0; ex_rs1 = '0; ex_rs2 = '0;
        ex_RegWrite = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0; ex_MemtoReg = 1'b0;
        ex_Branch = 1'b0; ex_Jump = 1'b0; ex_funct3 = '0;
        wb_rd = '0; wb_RegWrite = 1'b0;
    endtask

    // Predict the next register state from the current inputs, clock once,
    // then compare the popped expectation against the DUT.
    task automatic cycle();
        exp_t nxt;
        exp_t e;
        nxt = model;
        if (rst) begin
            nxt = '{default: '0};
            nxt.known = 1'b1;
        end else if (flush || (model.valid && model.pcsrc)) begin
            nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0;
            nxt.m2r = 1'b0; nxt.pcsrc = 1'b0; nxt.known = 1'b0;
        end else if (!stall) begin
            nxt.valid = ex_valid;
            nxt.rw    = ex_RegWrite & ex_valid;
            nxt.mr    = ex_MemRead & ex_valid;
            nxt.mw    = ex_MemWrite & ex_valid;
            nxt.m2r   = ex_MemtoReg & ex_valid;
            nxt.pcsrc = branch_taken() & ex_valid;
            nxt.alu   = ALUresult;
            nxt.wd    = finalReadData2;
            nxt.bt    = ex_branch_target;
            nxt.rd    = ex_rd;
            nxt.known = 1'b1;
        end
        sb_q.push_back(nxt);
        model = nxt;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("mem_valid",    32'(mem_valid),    32'(e.valid));
        chk("mem_RegWrite", 32'(mem_RegWrite), 32'(e.rw));
        chk("mem_MemRead",  32'(mem_MemRead),  32'(e.mr));
        chk("mem_MemWrite", 32'(mem_MemWrite), 32'(e.mw));
        chk("mem_MemtoReg", 32'(mem_MemtoReg), 32'(e.m2r));
        chk("mem_pcsrc",    32'(mem_pcsrc),    32'(e.pcsrc));
        if (e.known) begin
            chk("mem_ALUresult",     mem_ALUresult,     e.alu);
            chk("mem_writeData",     mem_writeData,     e.wd);
            chk("mem_branch_target", mem_branch_target, e.bt);
            chk("mem_rd",            32'(mem_rd),       32'(e.rd));
        end
    endtask

    task automatic check_fwd();
        logic luh;
        #1;
        luh = model.valid && model.mr && model.rd != 5'd0
              && (model.rd == ex_rs1 || model.rd == ex_rs2) && ex_valid;
        chk("forwardA",        32'(forwardA),        32'(exp_fwd(ex_rs1)));
        chk("forwardB",        32'(forwardB),        32'(exp_fwd(ex_rs2)));
        chk("load_use_hazard", 32'(load_use_hazard), 32'(luh));
    endtask

    initial begin
        model = '{default: '0};
        clr_ex();

        // Reset with garbage on the EX side.
        rst = 1'b1; stall = 1'b1; ex_valid = 1'b1; ex_RegWrite = 1'b1;
        ex_rd = 5'd9; ALUresult = 32'hdead_beef; ex_Jump = 1'b1;
        cycle();
        stall = 1'b0; flush = 1'b1;
        cycle();
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_alu",   mem_ALUresult, 32'd0);
        clr_ex();
        ex_valid = 1'b1; ex_rs1 = 5'd4; ex_rs2 = 5'd0;
        check_fwd();
        chk("rst_fwdA", 32'(forwardA), 32'd0);

        // Basic capture.
        clr_ex();
        ALUresult = 32'h1234; ex_rd = 5'd5; ex_RegWrite = 1'b1; ex_valid = 1'b1;
        cycle();
        chk("cap_alu", mem_ALUresult, 32'h1234);
        chk("cap_rd",  32'(mem_rd),   32'd5);

        // Forward priority: EX/MEM beats MEM/WB.
        clr_ex();
        ex_rd = 5'd3; ex_RegWrite = 1'b1; ex_valid = 1'b1; ALUresult = 32'h33;
        cycle();
        ex_rd = 5'd0; ex_rs1 = 5'd3; wb_rd = 5'd3; wb_RegWrite = 1'b1;
        check_fwd();
        chk("fwd_mem", 32'(forwardA), 32'b10);
        ex_rd = 5'd3; ex_rs1 = 5'd0; ex_RegWrite = 1'b0;
        cycle();
        ex_rs1 = 5'd3;
        check_fwd();
        chk("fwd_wb", 32'(forwardA), 32'b01);
        ex_rs1 = 5'd0;
        check_fwd();
        chk("fwd_x0", 32'(forwardA), 32'b00);

        // Load-use: no EX/MEM forward of a load.
        clr_ex();
        ex_valid = 1'b1; ex_rd = 5'd7; ex_RegWrite = 1'b1; ex_MemRead = 1'b1; ex_MemtoReg = 1'b1;
        cycle();
        clr_ex();
        ex_valid = 1'b1; ex_rs2 = 5'd7;
        check_fwd();
        chk("lu_hazard", 32'(load_use_hazard), 32'd1);
        chk("lu_fwdB",   32'(forwardB),        32'b00);
        wb_rd = 5'd7; wb_RegWrite = 1'b1;
        check_fwd();
        chk("lu_fwdB_wb", 32'(forwardB), 32'b01);

        // Taken branch, then the wrong-path instruction is squashed.
        clr_ex();
        ex_valid = 1'b1; ex_Branch = 1'b1; ex_funct3 = 3'b000; zero = 1'b1;
        ex_branch_target = 32'h40;
        cycle();
        chk("br_pcsrc",  32'(mem_pcsrc),  32'd1);
        chk("br_target", mem_branch_target, 32'h40);
        clr_ex();
        ex_valid = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd2;
        cycle();
        chk("br_squash_valid", 32'(mem_valid), 32'd0);
        chk("br_squash_pcsrc", 32'(mem_pcsrc), 32'd0);
        clr_ex();
        ex_valid = 1'b1; ex_Branch = 1'b1; ex_funct3 = 3'b001; zero = 1'b1;
        cycle();
        chk("bne_not_taken", 32'(mem_pcsrc), 32'd0);

        // Stall three cycles, then stall with flush.
        clr_ex();
        ex_valid = 1'b1; ALUresult = 32'h5555; ex_rd = 5'd6; ex_RegWrite = 1'b1; ex_MemWrite = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; ALUresult = 32'(i + 100); ex_rd = 5'(i + 10); ex_MemWrite = 1'b0;
            cycle();
        end
        chk("stall_hold", mem_ALUresult, 32'h5555);
        flush = 1'b1;
        cycle();
        chk("stall_flush_bubble", 32'(mem_valid), 32'd0);

        // Reset while a redirect is in MEM.
        clr_ex();
        ex_valid = 1'b1; ex_Jump = 1'b1; ex_branch_target = 32'h80; ex_RegWrite = 1'b1; ex_rd = 5'd1;
        cycle();
        clr_ex();
        rst = 1'b1; ex_valid = 1'b1; ex_Jump = 1'b1;
        cycle();
        chk("rst_mid_pcsrc",  32'(mem_pcsrc), 32'd0);
        chk("rst_mid_target", mem_branch_target, 32'd0);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            rst              = ($urandom_range(0, 49) == 0);
            stall            = ($urandom_range(0, 4) == 0);
            flush            = ($urandom_range(0, 9) == 0);
            ex_valid         = ($urandom_range(0, 3) != 0);
            ALUresult        = $urandom;
            finalReadData2   = $urandom;
            ex_branch_target = $urandom;
            zero             = ($urandom_range(0, 1) == 1);
            ex_rd            = 5'($urandom_range(0, 7));
            ex_rs1           = 5'($urandom_range(0, 7));
            ex_rs2           = 5'($urandom_range(0, 7));
            ex_RegWrite      = ($urandom_range(0, 1) == 1);
            ex_MemRead       = ($urandom_range(0, 2) == 0);
            ex_MemWrite      = ($urandom_range(0, 3) == 0);
            ex_MemtoReg      = ex_MemRead;
            ex_Branch        = ($urandom_range(0, 3) == 0);
            ex_Jump          = ($urandom_range(0, 11) == 0);
            ex_funct3        = 3'($urandom_range(0, 7));
            wb_rd            = 5'($urandom_range(0, 7));
            wb_RegWrite      = ($urandom_range(0, 1) == 1);
            check_fwd();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
